pspl_axil_slave_regs: RTL

AXI4-Lite slave register file answering the PS-side AXI master. It provides four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, and exports their values to PL fabric logic. Each register reads back exactly what was last written, with byte-lane masking. It is the responder end of the PS-to-PL control path used by the sequential write/readback bring-up test.

---
 rtl/pspl_axil_slave_regs.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pspl_axil_slave_regs.sv
// rtl/pspl_axil_slave_regs.sv - AXI4-Lite slave with four 32-bit byte-maskable registers exported to PL
module pspl_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  // Readys are held low during reset and only rise on the first edge after release.
  logic rst_done;

  logic [1:0]        aw_addr_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              commit, aw_latch, w_latch;
  logic [1:0]        commit_addr;
  logic [DW-1:0]     commit_data;
  logic [STRB_W-1:0] commit_strb;

  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] rdata_q;
  logic [3:0]    wr_pulse_q;

  // Protection bits and the byte-offset address bits carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = rst_done && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign S_AXI_WREADY  = rst_done && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign S_AXI_ARREADY = rst_done && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse_o    = wr_pulse_q;

  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Track the first clock edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rst_done <= 1'b0;
    else                rst_done <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  // Write FSM next state; commit uses live bus values for whichever half arrives last.
  always_comb begin
    w_next      = w_state;
    commit      = 1'b0;
    aw_latch    = 1'b0;
    w_latch     = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = S_AXI_AWADDR[3:2];
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_next      = W_RESP;
        end else if (aw_hs) begin
          aw_latch = 1'b1;
          w_next   = W_HAVE_AW;
        end else if (w_hs) begin
          w_latch = 1'b1;
          w_next  = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_next      = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = S_AXI_AWADDR[3:2];
          w_next      = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Hold whichever write half arrived first until its partner shows up.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_latch) aw_addr_q <= S_AXI_AWADDR[3:2];
      if (w_latch) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file: byte-lane masked update on the commit edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commit_strb[b]) regs_q[commit_addr][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
  end

  // One-cycle one-hot pulse marking which register was written, even with no strobes set.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  wr_pulse_q <= 4'b0000;
    else if (commit)     wr_pulse_q <= 4'b0001 << commit_addr;
    else                 wr_pulse_q <= 4'b0000;
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Capture read data at the AR handshake; a same-edge write is not yet visible.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rdata_q <= '0;
    else if (ar_hs)     rdata_q <= regs_q[S_AXI_ARADDR[3:2]];
  end

endmodule
